// File: rtl/pl_fetch_ctrl.sv
// pl_fetch_ctrl: instruction-fetch sequencer.
// Owns the PC, drives the combinational ROM address and queues fetched
// {pc, inst} pairs in a small FIFO that decode drains with valid/ready.
// Applies EX redirects (flush + new PC) and halts on fetch faults.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   fetch_en        level; 1 = fetch (IDLE -> RUN), 0 = stop fetching
//   imem_a          ROM address (= PC register)
//   imem_inst       ROM read data, combinational from imem_a
//   if_valid        head entry presented to decode
//   if_ready        decode accepts head this cycle
//   if_pc, if_inst  head entry payload (0 when queue empty)
//   redirect_valid  EX taken branch/jump pulse
//   redirect_pc     redirect target
//   fault           sticky fetch fault
//   fault_pc        offending PC (misaligned target or out-of-range PC)
module pl_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_inst,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic            r_fault;
  logic [31:0]     r_fault_pc;
  logic [31:0]     r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]     r_fifo_inst [FIFO_DEPTH];

  logic            w_redir;
  logic            w_misal;
  logic            w_in_range;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_range_fault;

  // Control decode for this cycle
  always_comb begin
    w_redir       = redirect_valid && (r_state != HALT);
    w_misal       = (redirect_pc[1:0] != 2'b00);
    w_in_range    = (r_pc < IMEM_BYTES);
    w_full        = (r_count == CW'(FIFO_DEPTH));
    w_pop         = if_valid && if_ready;
    // A simultaneous pop frees a slot, so a full queue can still accept
    w_push        = (r_state == RUN) && !redirect_valid && w_in_range &&
                    (!w_full || w_pop);
    w_range_fault = (r_state == RUN) && !redirect_valid && !w_in_range;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_redir && w_misal)  w_state_nxt = HALT;
        else if (w_redir)        w_state_nxt = IDLE;
        else if (fetch_en)       w_state_nxt = RUN;
      end
      RUN: begin
        if (w_redir && w_misal)  w_state_nxt = HALT;
        else if (w_range_fault)  w_state_nxt = HALT;
        else if (!fetch_en)      w_state_nxt = IDLE;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // PC, queue pointers and fault capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_count    <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else if (w_redir) begin
      // Redirect flushes the queue; a misaligned target halts instead of loading
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      if (w_misal) begin
        r_fault    <= 1'b1;
        r_fault_pc <= redirect_pc;
      end else begin
        r_pc <= redirect_pc;
      end
    end else begin
      if (w_push) begin
        r_wr <= r_wr + PW'(1);
        r_pc <= r_pc + 32'd4;
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_range_fault) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_pc;
      end
    end
  end

  // Queue storage; contents are qualified by r_count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push && !w_redir) begin
      r_fifo_pc[r_wr]   <= r_pc;
      r_fifo_inst[r_wr] <= imem_inst;
    end
  end

  // Output drive
  always_comb begin
    imem_a   = r_pc;
    if_valid = (r_count != '0) && !redirect_valid;
    if_pc    = (r_count != '0) ? r_fifo_pc[r_rd]   : 32'h0;
    if_inst  = (r_count != '0) ? r_fifo_inst[r_rd] : 32'h0;
    fault    = r_fault;
    fault_pc = r_fault_pc;
  end

endmodule
